alu_op_sequencer: RTL and testbench

- Command-side initiator for the 6-bit ALU.
- Buffers operation requests (A, B, fxn) in a small FIFO and drives the ALU operand/function inputs from registers.
- Waits a fixed settle time, captures X, and returns it on a valid/ready response channel.
- Sits between the control/test logic and the combinational ALU, so that ALU use becomes a clocked, back-pressurable transaction.

---
 rtl/alu_op_sequencer_if.sv | 41 ++++
 rtl/alu_op_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_op_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - command/ALU/response bundle for alu_op_sequencer
//
// Signals:
//   cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_fxn  command channel into the FIFO
//   alu_a/alu_b/alu_fxn/alu_x                registered operands out, ALU result in
//   rsp_valid/rsp_ready/rsp_x/rsp_fxn        result channel
//   busy/cmd_count                           engine status and FIFO occupancy
// Modports: slave = the sequencer, master = control/test logic plus ALU.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 6,
  parameter int FN_W   = 3,
  parameter int DEPTH  = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;
  logic [FN_W-1:0]   cmd_fxn;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [FN_W-1:0]   alu_fxn;
  logic [DATA_W-1:0] alu_x;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_x;
  logic [FN_W-1:0]   rsp_fxn;
  logic              busy;
  logic [CW-1:0]     cmd_count;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_fxn, alu_x, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_fxn, rsp_valid, rsp_x, rsp_fxn, busy, cmd_count
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_fxn, alu_x, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_fxn, rsp_valid, rsp_x, rsp_fxn, busy, cmd_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - FIFO-buffered, clocked initiator for the combinational ALU
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  alu_op_sequencer_if.slave (command, ALU and response channels, status)
// Commands queue in a DEPTH-entry FIFO. The engine pops one, holds the operands
// on the ALU for SETTLE cycles, captures the result and offers it until taken.
module alu_op_sequencer #(
  parameter int DATA_W = 6,
  parameter int FN_W   = 3,
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1
) (
  input logic             clk,
  input logic             rst,
  alu_op_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_d;

  logic [DATA_W-1:0] mem_a [DEPTH];
  logic [DATA_W-1:0] mem_b [DEPTH];
  logic [FN_W-1:0]   mem_f [DEPTH];

  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     cnt;
  logic [DATA_W-1:0] a_q, b_q, x_q;
  logic [FN_W-1:0]   f_q, xf_q;
  logic              valid_q;
  logic              push, pop, capture, rsp_done;

  assign bus.cmd_ready = (count != CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;

  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_fxn   = f_q;
  assign bus.rsp_valid = valid_q;
  assign bus.rsp_x     = x_q;
  assign bus.rsp_fxn   = xf_q;
  assign bus.busy      = (state != IDLE);
  assign bus.cmd_count = count;

  // Pop decision uses the registered count, so an entry written at this
  // same edge can never be popped at it.
  always_comb begin
    state_d  = state;
    pop      = 1'b0;
    capture  = 1'b0;
    rsp_done = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop     = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (cnt == '0) begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        rsp_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Storage needs no reset: only entries counted by the pointers are read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.cmd_a;
      mem_b[wr_ptr] <= bus.cmd_b;
      mem_f[wr_ptr] <= bus.cmd_fxn;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      x_q     <= '0;
      xf_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        a_q    <= mem_a[rd_ptr];
        b_q    <= mem_b[rd_ptr];
        f_q    <= mem_f[rd_ptr];
        cnt    <= SW'(SETTLE - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - SW'(1);
      end

      if (capture) begin
        x_q     <= bus.alu_x;
        xf_q    <= f_q;
        valid_q <= 1'b1;
      end else if (rsp_done) begin
        valid_q <= 1'b0;
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized and directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] exp_q [$];

  alu_op_sequencer_if #(.DATA_W(6), .FN_W(3), .DEPTH(4)) b1 ();
  alu_op_sequencer_if #(.DATA_W(6), .FN_W(3), .DEPTH(4)) b3 ();

  alu_op_sequencer #(.DATA_W(6), .FN_W(3), .DEPTH(4), .SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  alu_op_sequencer #(.DATA_W(6), .FN_W(3), .DEPTH(4), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .bus(b3.slave));

  function automatic logic [5:0] alu_ref(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
    logic [5:0] r;
    case (f)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = -a;
      3'b011:  r = a ^ b;
      3'b100:  r = {5'b0, (a < b)};
      3'b101:  r = ~(a ^ b);
      3'b110:  r = a + b;
      default: r = a - b;
    endcase
    return r;
  endfunction

  assign b1.alu_x = alu_ref(b1.alu_a, b1.alu_b, b1.alu_fxn);
  assign b3.alu_x = alu_ref(b3.alu_a, b3.alu_b, b3.alu_fxn);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic push1(input logic [5:0] a, input logic [5:0] b, input logic [2:0] f);
    int t = 0;
    @(negedge clk);
    b1.cmd_valid = 1'b1; b1.cmd_a = a; b1.cmd_b = b; b1.cmd_fxn = f;
    while (!b1.cmd_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("push_timeout", 0, 1);
    else exp_q.push_back({alu_ref(a, b, f), f});
    @(posedge clk); #1;
    b1.cmd_valid = 1'b0;
  endtask

  task automatic drain1(input logic [5:0] ex, input logic [2:0] ef);
    int t = 0;
    @(negedge clk);
    b1.rsp_ready = 1'b1;
    while (!b1.rsp_valid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) check("rsp_timeout", 0, 1);
    else begin
      check("rsp_x", b1.rsp_x, ex);
      check("rsp_fxn", b1.rsp_fxn, ef);
    end
    @(posedge clk); #1;
    b1.rsp_ready = 1'b0;
  endtask

  task automatic drain_q();
    logic [8:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      drain1(e[8:3], e[2:0]);
    end else check("drain_empty_model", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [5:0] ta [6];
    logic [5:0] tb [6];
    logic [2:0] tf [6];
    logic [5:0] held;
    logic [8:0] e;
    logic       rdy, seen, prev_stall;
    logic [5:0] prev_x;
    logic [2:0] prev_f;
    int acc, t;

    b1.cmd_valid = 0; b1.cmd_a = 0; b1.cmd_b = 0; b1.cmd_fxn = 0; b1.rsp_ready = 0;
    b3.cmd_valid = 0; b3.cmd_a = 0; b3.cmd_b = 0; b3.cmd_fxn = 0; b3.rsp_ready = 0;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", b1.cmd_ready, 1);
    check("rst_count", b1.cmd_count, 0);
    check("rst_busy", b1.busy, 0);
    check("rst_rsp_valid", b1.rsp_valid, 0);
    check("rst_alu_a", b1.alu_a, 0);
    check("rst_rsp_x", b1.rsp_x, 0);
    rst = 1'b0;

    // Single add, SETTLE=1
    @(negedge clk);
    b1.rsp_ready = 1; b1.cmd_valid = 1; b1.cmd_a = 6'd5; b1.cmd_b = 6'd3; b1.cmd_fxn = 3'b110;
    @(negedge clk);
    b1.cmd_valid = 0;
    check("add_count_e0", b1.cmd_count, 1);
    check("add_busy_e0", b1.busy, 0);
    @(negedge clk);
    check("add_alu_a", b1.alu_a, 5);
    check("add_alu_b", b1.alu_b, 3);
    check("add_alu_fxn", b1.alu_fxn, 3'b110);
    check("add_busy_e1", b1.busy, 1);
    check("add_valid_e1", b1.rsp_valid, 0);
    @(negedge clk);
    check("add_valid_e2", b1.rsp_valid, 1);
    check("add_rsp_x", b1.rsp_x, 6'd8);
    check("add_rsp_fxn", b1.rsp_fxn, 3'b110);
    @(negedge clk);
    check("add_valid_e3", b1.rsp_valid, 0);
    check("add_busy_e3", b1.busy, 0);
    b1.rsp_ready = 0;

    // In-order mix
    push1(6'd3, 6'd5, 3'b111);
    push1(6'b101010, 6'b100110, 3'b101);
    push1(6'd1, 6'd0, 3'b010);
    drain1(6'h3E, 3'b111);
    drain1(6'b110011, 3'b101);
    drain1(6'h3F, 3'b010);
    exp_q.delete();

    // Back-pressure: 6 back-to-back offers with rsp_ready low
    for (int i = 0; i < 6; i++) begin
      ta[i] = 6'($urandom); tb[i] = 6'($urandom); tf[i] = 3'($urandom);
    end
    b1.rsp_ready = 0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (acc < 6) begin
        b1.cmd_valid = 1; b1.cmd_a = ta[acc]; b1.cmd_b = tb[acc]; b1.cmd_fxn = tf[acc];
      end
      rdy = b1.cmd_ready;
      @(posedge clk);
      if (rdy && acc < 6) begin
        exp_q.push_back({alu_ref(ta[acc], tb[acc], tf[acc]), tf[acc]});
        acc++;
      end
    end
    @(negedge clk);
    check("bp_accepted", acc, 5);
    check("bp_cmd_ready", b1.cmd_ready, 0);
    check("bp_count", b1.cmd_count, 4);
    check("bp_rsp_valid", b1.rsp_valid, 1);
    held = b1.rsp_x;
    check("bp_rsp_first", b1.rsp_x, exp_q[0][8:3]);
    repeat (3) begin
      @(negedge clk);
      check("bp_stall_x", b1.rsp_x, held);
      check("bp_stall_valid", b1.rsp_valid, 1);
    end
    b1.rsp_ready = 1;
    @(posedge clk);
    @(negedge clk);
    b1.rsp_ready = 0;
    void'(exp_q.pop_front());
    check("bp_ready_after_hs", b1.cmd_ready, 0);
    check("bp_valid_after_hs", b1.rsp_valid, 0);
    @(negedge clk);
    check("bp_ready_after_pop", b1.cmd_ready, 1);
    check("bp_count_after_pop", b1.cmd_count, 3);
    @(posedge clk);
    exp_q.push_back({alu_ref(ta[5], tb[5], tf[5]), tf[5]});
    @(negedge clk);
    b1.cmd_valid = 0;
    check("bp_count_sixth", b1.cmd_count, 4);
    repeat (5) drain_q();

    // Simultaneous push and pop with two queued in IDLE
    push1(6'($urandom), 6'($urandom), 3'($urandom));
    push1(6'($urandom), 6'($urandom), 3'($urandom));
    push1(6'($urandom), 6'($urandom), 3'($urandom));
    t = 0;
    @(negedge clk);
    while (!b1.rsp_valid && t < 20) begin @(negedge clk); t++; end
    check("sp_count_pre", b1.cmd_count, 2);
    e = exp_q.pop_front();
    check("sp_rsp0_x", b1.rsp_x, e[8:3]);
    b1.rsp_ready = 1;
    @(negedge clk);
    b1.rsp_ready = 0;
    check("sp_idle", b1.busy, 0);
    check("sp_count_idle", b1.cmd_count, 2);
    ta[0] = 6'($urandom); tb[0] = 6'($urandom); tf[0] = 3'($urandom);
    b1.cmd_valid = 1; b1.cmd_a = ta[0]; b1.cmd_b = tb[0]; b1.cmd_fxn = tf[0];
    @(posedge clk);
    exp_q.push_back({alu_ref(ta[0], tb[0], tf[0]), tf[0]});
    @(negedge clk);
    b1.cmd_valid = 0;
    check("sp_count_post", b1.cmd_count, 2);
    check("sp_busy_post", b1.busy, 1);
    repeat (3) drain_q();

    // Asynchronous reset mid-stream
    push1(6'($urandom), 6'($urandom), 3'($urandom));
    push1(6'($urandom), 6'($urandom), 3'($urandom));
    push1(6'($urandom), 6'($urandom), 3'($urandom));
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    check("mrst_rsp_valid", b1.rsp_valid, 0);
    check("mrst_rsp_x", b1.rsp_x, 0);
    check("mrst_rsp_fxn", b1.rsp_fxn, 0);
    check("mrst_alu_a", b1.alu_a, 0);
    check("mrst_alu_b", b1.alu_b, 0);
    check("mrst_alu_fxn", b1.alu_fxn, 0);
    check("mrst_busy", b1.busy, 0);
    check("mrst_count", b1.cmd_count, 0);
    check("mrst_cmd_ready", b1.cmd_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst = 0;

    // SETTLE=3 latency: accept E0, pop E1, valid after E4
    b3.rsp_ready = 1;
    @(negedge clk);
    b3.cmd_valid = 1; b3.cmd_a = 6'd7; b3.cmd_b = 6'd9; b3.cmd_fxn = 3'b110;
    @(negedge clk);
    b3.cmd_valid = 0;
    @(negedge clk);
    check("s3_alu_a", b3.alu_a, 7);
    check("s3_valid_e1", b3.rsp_valid, 0);
    @(negedge clk);
    check("s3_valid_e2", b3.rsp_valid, 0);
    @(negedge clk);
    check("s3_valid_e3", b3.rsp_valid, 0);
    @(negedge clk);
    check("s3_valid_e4", b3.rsp_valid, 1);
    check("s3_rsp_x", b3.rsp_x, 6'h10);
    @(negedge clk);
    check("s3_valid_e5", b3.rsp_valid, 0);

    // Reset during WAIT with two queued
    @(negedge clk);
    b3.cmd_valid = 1; b3.cmd_a = 6'd1; b3.cmd_b = 6'd2; b3.cmd_fxn = 3'b110;
    @(negedge clk);
    b3.cmd_a = 6'd3; b3.cmd_b = 6'd4;
    @(negedge clk);
    b3.cmd_a = 6'd5; b3.cmd_b = 6'd6;
    @(negedge clk);
    b3.cmd_valid = 0;
    check("rw_count_pre", b3.cmd_count, 2);
    check("rw_busy_pre", b3.busy, 1);
    rst = 1;
    #1;
    check("rw_count_rst", b3.cmd_count, 0);
    check("rw_busy_rst", b3.busy, 0);
    check("rw_ready_rst", b3.cmd_ready, 1);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (b3.rsp_valid) seen = 1;
    end
    check("rw_no_rsp", seen, 0);
    check("rw_count_end", b3.cmd_count, 0);
    check("rw_busy_end", b3.busy, 0);
    b3.rsp_ready = 0;

    // Randomized traffic against the queue model
    prev_stall = 0; prev_x = 0; prev_f = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("rnd_stall_valid", b1.rsp_valid, 1);
        check("rnd_stall_x", b1.rsp_x, prev_x);
        check("rnd_stall_fxn", b1.rsp_fxn, prev_f);
      end
      b1.cmd_valid = ($urandom_range(0, 2) != 0);
      b1.cmd_a = 6'($urandom); b1.cmd_b = 6'($urandom); b1.cmd_fxn = 3'($urandom);
      b1.rsp_ready = 1'($urandom);
      if (b1.rsp_valid && b1.rsp_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rnd_rsp_x", b1.rsp_x, e[8:3]);
          check("rnd_rsp_fxn", b1.rsp_fxn, e[2:0]);
        end else check("rnd_unexpected_rsp", 1, 0);
      end
      if (b1.cmd_valid && b1.cmd_ready)
        exp_q.push_back({alu_ref(b1.cmd_a, b1.cmd_b, b1.cmd_fxn), b1.cmd_fxn});
      prev_stall = b1.rsp_valid && !b1.rsp_ready;
      prev_x = b1.rsp_x;
      prev_f = b1.rsp_fxn;
    end
    @(negedge clk);
    b1.cmd_valid = 0;
    b1.rsp_ready = 0;
    t = 0;
    while (exp_q.size() > 0 && t < 10) begin drain_q(); t++; end
    check("rnd_model_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    check("rnd_count_end", b1.cmd_count, 0);
    check("rnd_busy_end", b1.busy, 0);
    check("rnd_valid_end", b1.rsp_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
